// File: rtl/pipelined_controller_if.sv
// Control bus between the ARM pipeline controller and its datapath.
// The controller takes the slave view; the datapath (or a bench standing in for it) takes the master view.
interface pipelined_controller_if;
  logic [31:0] INSTR;
  logic [3:0]  ALUFlagsE;
  logic [1:0]  RegSrcD;
  logic [1:0]  ImmSrcD;
  logic        Sel14;
  logic        ALUSrcE;
  logic        FlagWriteE;
  logic [3:0]  ALUControlE;
  logic        MemWriteM;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic        PCSrcW;
  logic        StallF;
  logic        FlushD;
  logic        FlushE;
  logic [3:0]  Flags;

  modport master (
    output INSTR, ALUFlagsE,
    input  RegSrcD, ImmSrcD, Sel14, ALUSrcE, FlagWriteE, ALUControlE,
           MemWriteM, RegWriteW, MemtoRegW, PCSrcW, StallF, FlushD, FlushE, Flags
  );

  modport slave (
    input  INSTR, ALUFlagsE,
    output RegSrcD, ImmSrcD, Sel14, ALUSrcE, FlagWriteE, ALUControlE,
           MemWriteM, RegWriteW, MemtoRegW, PCSrcW, StallF, FlushD, FlushE, Flags
  );
endinterface

// File: rtl/pipelined_controller.sv
// Five-stage ARM pipeline control unit: D-stage decode, E/M/W control pipeline,
// NZCV flag register with condition check, and PC-write stall/flush generation.
module pipelined_controller (
  input logic CLK,
  input logic RESET,
  pipelined_controller_if.slave bus
);

  logic       validD;
  logic [1:0] regSrcD, immSrcD;
  logic       sel14D, regWriteD, memWriteD, memtoRegD, aluSrcD, flagWD, branchD, pcsD;
  logic [3:0] aluControlD;

  logic       regWriteE, memWriteE, memtoRegE, aluSrcE, flagWE, pcsE;
  logic [3:0] aluControlE, condE;
  logic       condExE;

  logic       regWriteM, memWriteM, memtoRegM, pcsM, pcsPendM;
  logic       regWriteW, memtoRegW, pcsW;
  logic [3:0] flags;
  logic       pcWrPending, flushD;
  logic       unusedInstrBits;

  assign unusedInstrBits = ^bus.INSTR[3:0];

  // Decode is forced to a NOP whenever the D slot holds a flushed or reset instruction.
  always_comb begin
    regSrcD     = 2'b00;
    immSrcD     = 2'b00;
    sel14D      = 1'b0;
    regWriteD   = 1'b0;
    memWriteD   = 1'b0;
    memtoRegD   = 1'b0;
    aluSrcD     = 1'b0;
    flagWD      = 1'b0;
    branchD     = 1'b0;
    aluControlD = 4'b0000;
    if (validD) begin
      if (bus.INSTR[27:4] == 24'h12FFF1) begin
        aluControlD = 4'b1101;
        branchD     = 1'b1;
      end else begin
        case (bus.INSTR[27:26])
          2'b00: begin
            aluControlD = bus.INSTR[24:21];
            aluSrcD     = bus.INSTR[25];
            if (bus.INSTR[24:23] == 2'b10) begin
              flagWD = 1'b1;
            end else begin
              regWriteD = 1'b1;
              flagWD    = bus.INSTR[20];
            end
          end
          2'b01: begin
            aluSrcD     = 1'b1;
            immSrcD     = 2'b01;
            aluControlD = bus.INSTR[23] ? 4'b0100 : 4'b0010;
            if (bus.INSTR[20]) begin
              regWriteD = 1'b1;
              memtoRegD = 1'b1;
            end else begin
              memWriteD  = 1'b1;
              regSrcD[1] = 1'b1;
            end
          end
          2'b10: begin
            regSrcD[0]  = 1'b1;
            immSrcD     = 2'b10;
            aluSrcD     = 1'b1;
            aluControlD = 4'b0100;
            branchD     = 1'b1;
            if (bus.INSTR[24]) begin
              regWriteD = 1'b1;
              sel14D    = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pcsD = branchD | (regWriteD & (bus.INSTR[15:12] == 4'hF));

  // Condition check against the architectural flags; 1111 never executes.
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (condE)
      4'b0000: condExE = z;
      4'b0001: condExE = ~z;
      4'b0010: condExE = c;
      4'b0011: condExE = ~c;
      4'b0100: condExE = n;
      4'b0101: condExE = ~n;
      4'b0110: condExE = v;
      4'b0111: condExE = ~v;
      4'b1000: condExE = c & ~z;
      4'b1001: condExE = ~c | z;
      4'b1010: condExE = (n == v);
      4'b1011: condExE = (n != v);
      4'b1100: condExE = ~z & (n == v);
      4'b1101: condExE = z | (n != v);
      4'b1110: condExE = 1'b1;
      default: condExE = 1'b0;
    endcase
  end

  // Hazard window uses the ungated PCS so a not-taken branch stalls exactly as long as a taken one.
  assign pcWrPending = pcsD | pcsE | pcsPendM;
  assign flushD      = pcWrPending | pcsW;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      validD      <= 1'b0;
      regWriteE   <= 1'b0;
      memWriteE   <= 1'b0;
      memtoRegE   <= 1'b0;
      aluSrcE     <= 1'b0;
      aluControlE <= 4'b0000;
      flagWE      <= 1'b0;
      pcsE        <= 1'b0;
      condE       <= 4'b0000;
      regWriteM   <= 1'b0;
      memWriteM   <= 1'b0;
      memtoRegM   <= 1'b0;
      pcsM        <= 1'b0;
      pcsPendM    <= 1'b0;
      regWriteW   <= 1'b0;
      memtoRegW   <= 1'b0;
      pcsW        <= 1'b0;
      flags       <= 4'b0000;
    end else begin
      validD      <= ~flushD;
      regWriteE   <= regWriteD;
      memWriteE   <= memWriteD;
      memtoRegE   <= memtoRegD;
      aluSrcE     <= aluSrcD;
      aluControlE <= aluControlD;
      flagWE      <= flagWD;
      pcsE        <= pcsD;
      condE       <= bus.INSTR[31:28];
      regWriteM   <= regWriteE & condExE;
      memWriteM   <= memWriteE & condExE;
      memtoRegM   <= memtoRegE;
      pcsM        <= pcsE & condExE;
      pcsPendM    <= pcsE;
      regWriteW   <= regWriteM;
      memtoRegW   <= memtoRegM;
      pcsW        <= pcsM;
      if (flagWE & condExE) begin
        flags <= bus.ALUFlagsE;
      end
    end
  end

  assign bus.RegSrcD     = regSrcD;
  assign bus.ImmSrcD     = immSrcD;
  assign bus.Sel14       = sel14D;
  assign bus.ALUSrcE     = aluSrcE;
  assign bus.FlagWriteE  = flagWE & condExE;
  assign bus.ALUControlE = aluControlE;
  assign bus.MemWriteM   = memWriteM;
  assign bus.RegWriteW   = regWriteW;
  assign bus.MemtoRegW   = memtoRegW;
  assign bus.PCSrcW      = pcsW;
  assign bus.StallF      = pcWrPending;
  assign bus.FlushD      = flushD;
  assign bus.FlushE      = ~validD;
  assign bus.Flags       = flags;

endmodule

// File: tb/tb_pipelined_controller.sv
// Bench for pipelined_controller: decode table, hand-written branch/flag/reset sequences,
// and randomized instruction streams compared every cycle against an in-bench pipeline model.
module tb_pipelined_controller;

  localparam logic [31:0] NOP   = 32'hEC000000;
  localparam logic [31:0] SUBS  = 32'hE0511001;
  localparam logic [31:0] ADDEQ = 32'h00812001;
  localparam logic [31:0] BL    = 32'hEB000002;
  localparam logic [31:0] BNE   = 32'h1A000002;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int checks = 0;
  int failures = 0;

  pipelined_controller_if bus ();

  pipelined_controller dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] cond;
    logic       regW, memW, memtoReg, aluSrc;
    logic [3:0] aluCtl;
    logic       flagW, pcs;
    logic [1:0] regSrc, immSrc;
    logic       sel14;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic ran;
  } slot_t;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  expD;
    logic [5:0]  expE;
    logic        expM;
    logic [2:0]  expW;
  } vec_t;

  // Model state: slot k is the instruction that left D k edges ago.
  logic       mValid, nValid;
  logic [3:0] mFlags, nFlags;
  slot_t      mPipe [1:3];
  slot_t      nPipe [1:3];

  function automatic ctl_t decodeRef(input logic [31:0] i);
    ctl_t c;
    c = '0;
    c.cond = i[31:28];
    if (i[27:4] == 24'h12FFF1) begin
      c.aluCtl = 4'b1101;
      c.pcs    = 1'b1;
    end else if (i[27:26] == 2'b00) begin
      c.aluCtl = i[24:21];
      c.aluSrc = i[25];
      c.flagW  = (i[24:23] == 2'b10) ? 1'b1 : i[20];
      c.regW   = (i[24:23] != 2'b10);
    end else if (i[27:26] == 2'b01) begin
      c.aluSrc   = 1'b1;
      c.immSrc   = 2'b01;
      c.aluCtl   = i[23] ? 4'b0100 : 4'b0010;
      c.regW     = i[20];
      c.memtoReg = i[20];
      c.memW     = ~i[20];
      c.regSrc   = {~i[20], 1'b0};
    end else if (i[27:26] == 2'b10) begin
      c.regSrc = 2'b01;
      c.immSrc = 2'b10;
      c.aluSrc = 1'b1;
      c.aluCtl = 4'b0100;
      c.pcs    = 1'b1;
      c.regW   = i[24];
      c.sel14  = i[24];
    end
    if (c.regW && i[15:12] == 4'hF) c.pcs = 1'b1;
    return c;
  endfunction

  function automatic logic condHolds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [21:0] actualOut();
    return {bus.RegSrcD, bus.ImmSrcD, bus.Sel14, bus.ALUSrcE, bus.FlagWriteE, bus.ALUControlE,
            bus.MemWriteM, bus.RegWriteW, bus.MemtoRegW, bus.PCSrcW, bus.StallF, bus.FlushD,
            bus.FlushE, bus.Flags};
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    logic [3:0]  cond;
    cond = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hE;
    r = {cond, 28'($urandom)};
    case ($urandom_range(0, 5))
      0: r[27:26] = 2'b00;
      1: r[27:26] = 2'b01;
      2: r[27:26] = 2'b10;
      3: r[27:26] = 2'b11;
      4: r[27:4]  = 24'h12FFF1;
      default: begin
        r[27:26] = 2'b00;
        r[15:12] = 4'hF;
      end
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelClear();
    mValid = 1'b0;
    mFlags = 4'b0000;
    nValid = 1'b0;
    nFlags = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      mPipe[k] = '0;
      nPipe[k] = '0;
    end
  endtask

  // Drive one cycle of inputs, compare every output against the model, and prepare the model's next state.
  task automatic applyStimulus(input logic [31:0] instr, input logic [3:0] aluf, input logic rstN);
    ctl_t        dec;
    logic        eRan, stall, pcsrc, flushD, flagWr;
    logic [21:0] exp;
    RESET = rstN;
    bus.INSTR = instr;
    bus.ALUFlagsE = aluf;
    #2;
    if (!rstN) modelClear();
    dec = '0;
    if (mValid) dec = decodeRef(instr);
    eRan   = condHolds(mPipe[1].c.cond, mFlags);
    flagWr = mPipe[1].c.flagW & eRan;
    stall  = dec.pcs | mPipe[1].c.pcs | mPipe[2].c.pcs;
    pcsrc  = mPipe[3].c.pcs & mPipe[3].ran;
    flushD = stall | pcsrc;
    exp = {dec.regSrc, dec.immSrc, dec.sel14, mPipe[1].c.aluSrc, flagWr, mPipe[1].c.aluCtl,
           mPipe[2].c.memW & mPipe[2].ran, mPipe[3].c.regW & mPipe[3].ran, mPipe[3].c.memtoReg,
           pcsrc, stall, flushD, ~mValid, mFlags};
    checkOutput("cycle outputs", 32'(actualOut()), 32'(exp));
    nPipe[3] = mPipe[2];
    nPipe[2] = '{c: mPipe[1].c, ran: eRan};
    nPipe[1] = '{c: dec, ran: 1'b0};
    nFlags   = flagWr ? aluf : mFlags;
    nValid   = ~flushD;
    if (!rstN) modelClear();
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
    mValid = nValid;
    mFlags = nFlags;
    for (int k = 1; k <= 3; k++) mPipe[k] = nPipe[k];
  endtask

  task automatic runCondSeq(input logic [3:0] aluf, input logic expRegW, input string tag);
    applyStimulus(SUBS, 4'h0, 1'b1);
    nextCycle();
    applyStimulus(ADDEQ, aluf, 1'b1);
    checkOutput({tag, " SUBS FlagWriteE"}, 32'(bus.FlagWriteE), 32'd1);
    nextCycle();
    applyStimulus(NOP, 4'h0, 1'b1);
    checkOutput({tag, " Flags"}, 32'(bus.Flags), 32'(aluf));
    nextCycle();
    applyStimulus(NOP, 4'h0, 1'b1);
    nextCycle();
    applyStimulus(NOP, 4'h0, 1'b1);
    checkOutput({tag, " ADDEQ RegWriteW"}, 32'(bus.RegWriteW), 32'(expRegW));
    nextCycle();
  endtask

  task automatic branchSeq(input logic [31:0] instr, input logic taken, input logic isBL, input string tag);
    for (int k = 0; k <= 4; k++) begin
      applyStimulus((k == 0) ? instr : ((k == 4) ? NOP : randInstr()), 4'($urandom), 1'b1);
      checkOutput($sformatf("%s StallF n+%0d", tag, k), 32'(bus.StallF), 32'(k <= 2));
      checkOutput($sformatf("%s FlushD n+%0d", tag, k), 32'(bus.FlushD), 32'(taken ? (k <= 3) : (k <= 2)));
      checkOutput($sformatf("%s PCSrcW n+%0d", tag, k), 32'(bus.PCSrcW), 32'(taken && k == 3));
      if (isBL) begin
        checkOutput($sformatf("%s RegWriteW n+%0d", tag, k), 32'(bus.RegWriteW), 32'(k == 3));
        if (k == 0) checkOutput({tag, " D controls"}, 32'({bus.Sel14, bus.RegSrcD, bus.ImmSrcD}), 32'(5'b1_01_10));
      end
      nextCycle();
    end
  endtask

  vec_t vecs [12];

  initial begin
    bus.INSTR = NOP;
    bus.ALUFlagsE = 4'h0;
    modelClear();

    vecs[0]  = '{32'hE2821005, 6'b00_00_0_0, 6'b1_0100_0, 1'b0, 3'b100};
    vecs[1]  = '{32'hE0511001, 6'b00_00_0_0, 6'b0_0010_1, 1'b0, 3'b100};
    vecs[2]  = '{32'hE1510002, 6'b00_00_0_0, 6'b0_1010_1, 1'b0, 3'b000};
    vecs[3]  = '{32'hE5812004, 6'b10_01_0_0, 6'b1_0100_0, 1'b1, 3'b000};
    vecs[4]  = '{32'hE5912004, 6'b00_01_0_0, 6'b1_0100_0, 1'b0, 3'b110};
    vecs[5]  = '{32'hE5112004, 6'b00_01_0_0, 6'b1_0010_0, 1'b0, 3'b110};
    vecs[6]  = '{32'hEB000002, 6'b01_10_1_1, 6'b1_0100_0, 1'b0, 3'b101};
    vecs[7]  = '{32'hEA000002, 6'b01_10_0_1, 6'b1_0100_0, 1'b0, 3'b001};
    vecs[8]  = '{32'hE12FFF1E, 6'b00_00_0_1, 6'b0_1101_0, 1'b0, 3'b001};
    vecs[9]  = '{32'hE1A0F00E, 6'b00_00_0_1, 6'b0_1101_0, 1'b0, 3'b101};
    vecs[10] = '{32'hEC000000, 6'b00_00_0_0, 6'b0_0000_0, 1'b0, 3'b000};
    vecs[11] = '{32'hF0812001, 6'b00_00_0_0, 6'b0_0100_0, 1'b0, 3'b000};

    // Reset held with random inputs: only FlushE is high.
    for (int k = 0; k < 3; k++) begin
      applyStimulus($urandom, 4'($urandom), 1'b0);
      checkOutput($sformatf("reset outputs %0d", k), 32'(actualOut()), 32'h10);
      nextCycle();
    end
    applyStimulus(NOP, 4'h0, 1'b1);
    checkOutput("FlushE right after release", 32'(bus.FlushE), 32'd1);
    nextCycle();
    applyStimulus(NOP, 4'h0, 1'b1);
    checkOutput("FlushE one edge after release", 32'(bus.FlushE), 32'd0);
    nextCycle();

    // Decode table: each vector runs from a clean pipeline with Flags=0000.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(NOP, 4'h0, 1'b0);
      nextCycle();
      applyStimulus(NOP, 4'h0, 1'b1);
      nextCycle();
      applyStimulus(vecs[i].instr, 4'h0, 1'b1);
      checkOutput($sformatf("vec%0d D", i), 32'({bus.RegSrcD, bus.ImmSrcD, bus.Sel14, bus.StallF}), 32'(vecs[i].expD));
      nextCycle();
      applyStimulus(NOP, 4'h0, 1'b1);
      checkOutput($sformatf("vec%0d E", i), 32'({bus.ALUSrcE, bus.ALUControlE, bus.FlagWriteE}), 32'(vecs[i].expE));
      nextCycle();
      applyStimulus(NOP, 4'h0, 1'b1);
      checkOutput($sformatf("vec%0d M", i), 32'(bus.MemWriteM), 32'(vecs[i].expM));
      nextCycle();
      applyStimulus(NOP, 4'h0, 1'b1);
      checkOutput($sformatf("vec%0d W", i), 32'({bus.RegWriteW, bus.MemtoRegW, bus.PCSrcW}), 32'(vecs[i].expW));
      nextCycle();
    end

    // Flag update feeding a conditional follower; the second run leaves Z set for BNE.
    runCondSeq(4'b0000, 1'b0, "EQ fails");
    runCondSeq(4'b0100, 1'b1, "EQ holds");
    branchSeq(BNE, 1'b0, 1'b0, "BNE not taken");
    branchSeq(BL, 1'b1, 1'b1, "BL taken");

    // Reset dropped while a BL is in E: outputs clear at once and nothing surfaces after release.
    applyStimulus(BL, 4'h0, 1'b1);
    nextCycle();
    applyStimulus(randInstr(), 4'h0, 1'b1);
    RESET = 1'b0;
    #1;
    checkOutput("async reset mid-branch", 32'(actualOut()), 32'h10);
    modelClear();
    nextCycle();
    applyStimulus(NOP, 4'h0, 1'b0);
    nextCycle();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(NOP, 4'h0, 1'b1);
      checkOutput($sformatf("no PCSrcW after reset %0d", k), 32'(bus.PCSrcW), 32'd0);
      nextCycle();
    end

    // Random instruction streams with occasional resets.
    for (int k = 0; k < 800; k++) begin
      applyStimulus(randInstr(), 4'($urandom), ($urandom_range(0, 79) != 0));
      nextCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
